// File: rtl/keypad_emulator.sv
// Keypad emulator: answers a 4x4 matrix scanner as if one queued key were held,
// pressing for HOLD_CYCLES and then guaranteeing GAP_CYCLES of release.
module keypad_emulator #(
  parameter int HOLD_CYCLES = 2000,
  parameter int GAP_CYCLES  = 2000,
  parameter int CNT_W       = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic       key_abort,
  input  logic [3:0] IO_P4_COL,
  output logic [3:0] IO_P4_ROW,
  output logic       busy,
  output logic       done,
  output logic [1:0] fsm_state
);

  // Handshake: a key is taken on a rising clk edge where key_valid and key_ready
  // are both high; key_valid without key_ready is dropped, never queued.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int GAP_EFF  = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_EFF - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       code;

  // Saturating increment so a mis-sized counter sticks rather than wraps.
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      code  <= 4'h0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (key_valid) begin
            code  <= key_code;
            cnt   <= '0;
            state <= PRESS;
          end
        end
        PRESS: begin
          if (key_abort || (cnt >= HOLD_LAST)) begin
            cnt   <= '0;
            state <= RELEASE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RELEASE: begin
          if (cnt >= GAP_LAST) begin
            cnt   <= '0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign key_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  // Rows follow the live column drive so the scanner sees the key only in its column slot.
  always_comb begin
    IO_P4_ROW = 4'b1111;
    if ((state == PRESS) && !IO_P4_COL[code[1:0]]) begin
      IO_P4_ROW[code[3:2]] = 1'b0;
    end
  end

endmodule
